// File: rtl/optical_pkg.sv
// Shared types and defaults for the optical-gate schedulers.
// Holds the FSM state encoding and the default medium settle / laser cool-down times.
package optical_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    SAMPLE = 3'd2,
    RESP   = 3'd3,
    COOL   = 3'd4
  } state_t;

  localparam int DEF_SETTLE_CYC = 3;
  localparam int DEF_COOL_CYC   = 2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping to 0.
// Zero latency; no backpressure, the caller decides when the winner is consumed.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [NREQ-1:0] o_win,
  output logic [ID_W-1:0] o_idx
);

  logic            w_found;
  logic [ID_W-1:0] w_j;

  always_comb begin
    o_win   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = ID_W'((int'(i_ptr) + k) % NREQ);
      if (!w_found && i_req[w_j]) begin
        w_found    = 1'b1;
        o_win[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/optical_and_scheduler.sv
// Shares one optical AND gate among NREQ requesters: grant, settle lasers, sample, respond, cool.
// gnt at t -> rsp_valid at t+SETTLE_CYC+2; rsp_ready low holds the response and blocks new grants.
module optical_and_scheduler
  import optical_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int COOL_CYC   = DEF_COOL_CYC,
  localparam int CNT_W     = $clog2(max2(SETTLE_CYC, COOL_CYC) + 1),
  localparam int ID_W      = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] op_a,
  input  logic [NREQ-1:0] op_b,
  output logic [NREQ-1:0] gnt,
  output logic            laser_a_en,
  output logic            laser_b_en,
  input  logic            det_y,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [ID_W-1:0] rsp_id,
  output logic            rsp_data,
  output logic            busy
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] COOL_LD   = CNT_W'((COOL_CYC > 0) ? COOL_CYC - 1 : 0);

  state_t          r_state;
  state_t          w_next;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_id;
  logic            r_cap_a;
  logic            r_cap_b;
  logic            r_data;
  logic [CNT_W-1:0] r_tmr;
  logic [NREQ-1:0] w_win;
  logic [ID_W-1:0] w_idx;
  logic            w_tmr_zero;
  logic            w_take;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_win (w_win),
    .o_idx (w_idx)
  );

  assign w_tmr_zero = (r_tmr == '0);
  assign w_take     = (r_state == IDLE) && (|req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (|req) w_next = SETTLE;
      SETTLE:  if (w_tmr_zero) w_next = SAMPLE;
      SAMPLE:  w_next = RESP;
      RESP:    if (rsp_ready) w_next = (COOL_CYC > 0) ? COOL : IDLE;
      COOL:    if (w_tmr_zero) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    gnt        = (r_state == IDLE) ? w_win : '0;
    laser_a_en = ((r_state == SETTLE) || (r_state == SAMPLE)) && r_cap_a;
    laser_b_en = ((r_state == SETTLE) || (r_state == SAMPLE)) && r_cap_b;
    rsp_valid  = (r_state == RESP);
    rsp_id     = r_id;
    rsp_data   = r_data;
    busy       = (r_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_id    <= '0;
      r_cap_a <= 1'b0;
      r_cap_b <= 1'b0;
    end else if (w_take) begin
      r_ptr   <= (w_idx == ID_W'(NREQ - 1)) ? '0 : w_idx + 1'b1;
      r_id    <= w_idx;
      r_cap_a <= op_a[w_idx];
      r_cap_b <= op_b[w_idx];
    end
  end

  // Timer reaches zero on every SETTLE/COOL exit, so it only needs loading on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr <= '0;
    end else if (w_take) begin
      r_tmr <= SETTLE_LD;
    end else if ((r_state == RESP) && (w_next == COOL)) begin
      r_tmr <= COOL_LD;
    end else if (!w_tmr_zero) begin
      r_tmr <= r_tmr - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_data <= 1'b0;
    else if (r_state == SAMPLE)  r_data <= det_y;
  end

endmodule
